// File: rtl/game_judge.sv
// Per-frame collision and win/lose judge: a tick-advanced 3-stage pipeline
// (abs diffs -> contact flags -> judge FSM) driving over/success pulses, lives and invuln.
module game_judge #(
    parameter int HIT_TICKS    = 2,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       running,
    input  logic [9:0] mario_x,
    input  logic [8:0] mario_y,
    input  logic [9:0] barrel_x,
    input  logic [8:0] barrel_y,
    input  logic [9:0] queue_x,
    input  logic [8:0] queue_y,
    output logic       over,
    output logic       success,
    output logic [1:0] lives,
    output logic       invuln,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_INVULN = 3'd2,
        S_OVER   = 3'd3,
        S_WIN    = 3'd4
    } state_t;

    localparam logic [1:0] LIVES_L  = 2'(LIVES);
    localparam logic [2:0] HIT_L    = 3'(HIT_TICKS);
    localparam logic [5:0] INVULN_L = 6'(INVULN_TICKS);

    function automatic logic [9:0] absdiff10(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [8:0] absdiff9(input logic [8:0] a, input logic [8:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // Pipeline: s1 holds diffs of the ticked sample, s2 holds contact flags.
    logic       s1_v, s2_v;
    logic [9:0] dxb_q, dxq_q;
    logic [8:0] dyb_q, dyq_q;
    logic       b_hit_q, q_hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            dxb_q   <= '0;
            dxq_q   <= '0;
            dyb_q   <= '0;
            dyq_q   <= '0;
            b_hit_q <= 1'b0;
            q_hit_q <= 1'b0;
        end else if (!running) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= tick;
            s2_v <= s1_v;
            if (tick) begin
                dxb_q <= absdiff10(mario_x, barrel_x);
                dyb_q <= absdiff9(mario_y, barrel_y);
                dxq_q <= absdiff10(mario_x, queue_x);
                dyq_q <= absdiff9(mario_y, queue_y);
            end
            if (s1_v) begin
                b_hit_q <= (dxb_q < 10'd50) && (dyb_q < 9'd70);
                q_hit_q <= (dxq_q < 10'd60) && (dyq_q < 9'd90);
            end
        end
    end

    state_t     state_q, state_n;
    logic [1:0] lives_q, lives_n;
    logic [2:0] hcnt_q, hcnt_n, hcnt_inc;
    logic [5:0] icnt_q, icnt_n, icnt_dec;
    logic [1:0] lives_dec;
    logic       over_n, success_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lives_q <= LIVES_L;
            hcnt_q  <= '0;
            icnt_q  <= '0;
            over    <= 1'b0;
            success <= 1'b0;
        end else begin
            state_q <= state_n;
            lives_q <= lives_n;
            hcnt_q  <= hcnt_n;
            icnt_q  <= icnt_n;
            over    <= over_n;
            success <= success_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        lives_n   = lives_q;
        hcnt_n    = hcnt_q;
        icnt_n    = icnt_q;
        over_n    = 1'b0;
        success_n = 1'b0;
        hcnt_inc  = (hcnt_q == HIT_L) ? hcnt_q : hcnt_q + 3'd1;
        lives_dec = lives_q - 2'd1;
        icnt_dec  = icnt_q - 6'd1;

        if (!running) begin
            state_n = S_IDLE;
            lives_n = LIVES_L;
            hcnt_n  = '0;
            icnt_n  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n = S_PLAY;
                    lives_n = LIVES_L;
                    hcnt_n  = '0;
                    icnt_n  = '0;
                end
                S_PLAY: begin
                    if (s2_v) begin
                        // Queue contact outranks a barrel hit confirmed on the same tick.
                        if (q_hit_q) begin
                            success_n = 1'b1;
                            state_n   = S_WIN;
                        end else if (!b_hit_q) begin
                            hcnt_n = '0;
                        end else if (hcnt_inc == HIT_L) begin
                            lives_n = lives_dec;
                            hcnt_n  = '0;
                            if (lives_dec == 2'd0) begin
                                over_n  = 1'b1;
                                state_n = S_OVER;
                            end else begin
                                icnt_n  = INVULN_L;
                                state_n = S_INVULN;
                            end
                        end else begin
                            hcnt_n = hcnt_inc;
                        end
                    end
                end
                S_INVULN: begin
                    hcnt_n = '0;
                    if (s2_v) begin
                        if (q_hit_q) begin
                            success_n = 1'b1;
                            state_n   = S_WIN;
                        end else begin
                            icnt_n = icnt_dec;
                            if (icnt_dec == 6'd0) state_n = S_PLAY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lives     = lives_q;
    assign invuln    = (state_q == S_INVULN);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_game_judge.sv
// Directed bench for game_judge: table of single-game collision vectors plus
// hand-written sequences for reset, debounce, game over, priority and abort.
module tb_game_judge;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       running = 1'b0;
    logic [9:0] mario_x = 10'd100, barrel_x = 10'd800, queue_x = 10'd900;
    logic [8:0] mario_y = 9'd100, barrel_y = 9'd400, queue_y = 9'd450;
    logic       over, success, invuln;
    logic [1:0] lives;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;
    int over_cnt = 0;
    int succ_cnt = 0;

    game_judge dut (
        .clk(clk), .rst(rst), .tick(tick), .running(running),
        .mario_x(mario_x), .mario_y(mario_y),
        .barrel_x(barrel_x), .barrel_y(barrel_y),
        .queue_x(queue_x), .queue_y(queue_y),
        .over(over), .success(success), .lives(lives), .invuln(invuln),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse monitor: counts pulse cycles and checks over/success exclusivity.
    always @(negedge clk) begin
        if (over) over_cnt++;
        if (success) succ_cnt++;
        if (over && success) check("pulse_exclusive", 1, 0);
    end

    task automatic set_barrel(input logic [9:0] x, input logic [8:0] y);
        barrel_x = x;
        barrel_y = y;
    endtask

    task automatic set_queue(input logic [9:0] x, input logic [8:0] y);
        queue_x = x;
        queue_y = y;
    endtask

    // One tick; returns at the negedge inside cycle T+3 where results are visible.
    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic start_game();
        @(negedge clk) running = 1'b0;
        @(negedge clk) running = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic [9:0] bx;
        logic [8:0] by;
        logic [9:0] qx;
        logic [8:0] qy;
        int         exp_lives;
        int         exp_inv;
        int         exp_succ;
    } vec_t;

    vec_t vecs[10];
    int   o0, s0;

    initial begin
        // Mario sits at (100,100) for every vector; far = no contact.
        vecs[0] = '{"barrel_edge_in",   10'd149, 9'd169, 10'd900, 9'd450, 2, 1, 0};
        vecs[1] = '{"barrel_dx50",      10'd150, 9'd100, 10'd900, 9'd450, 3, 0, 0};
        vecs[2] = '{"barrel_dy70",      10'd100, 9'd170, 10'd900, 9'd450, 3, 0, 0};
        vecs[3] = '{"barrel_low_in",    10'd51,  9'd31,  10'd900, 9'd450, 2, 1, 0};
        vecs[4] = '{"barrel_low_dx50",  10'd50,  9'd100, 10'd900, 9'd450, 3, 0, 0};
        vecs[5] = '{"queue_edge_in",    10'd800, 9'd400, 10'd159, 9'd189, 3, 0, 1};
        vecs[6] = '{"queue_dx60",       10'd800, 9'd400, 10'd160, 9'd100, 3, 0, 0};
        vecs[7] = '{"queue_dy90",       10'd800, 9'd400, 10'd100, 9'd190, 3, 0, 0};
        vecs[8] = '{"queue_low_in",     10'd800, 9'd400, 10'd41,  9'd11,  3, 0, 1};
        vecs[9] = '{"both_full_lives",  10'd100, 9'd100, 10'd100, 9'd100, 3, 0, 1};

        // Reset held with running high and overlapping boxes.
        running = 1'b1;
        set_barrel(10'd100, 9'd100);
        set_queue(10'd100, 9'd100);
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_over", over, 0);
        check("rst_success", success, 0);
        check("rst_lives", lives, 3);
        check("rst_invuln", invuln, 0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_over_cnt", over_cnt, 0);
        check("post_rst_succ_cnt", succ_cnt, 0);
        check("post_rst_lives", lives, 3);
        set_queue(10'd900, 9'd450);

        // Table-driven single-game vectors: two ticks each from a fresh game.
        foreach (vecs[i]) begin
            start_game();
            set_barrel(vecs[i].bx, vecs[i].by);
            set_queue(vecs[i].qx, vecs[i].qy);
            o0 = over_cnt;
            s0 = succ_cnt;
            run_ticks(2);
            check({vecs[i].name, "_lives"}, lives, vecs[i].exp_lives);
            check({vecs[i].name, "_invuln"}, invuln, vecs[i].exp_inv);
            check({vecs[i].name, "_success"}, succ_cnt - s0, vecs[i].exp_succ);
            check({vecs[i].name, "_over"}, over_cnt - o0, 0);
        end
        set_queue(10'd900, 9'd450);

        // Debounce: contact, gap, contact does not confirm; the next contact does.
        start_game();
        set_barrel(10'd100, 9'd100);
        do_tick();
        set_barrel(10'd800, 9'd400);
        do_tick();
        set_barrel(10'd100, 9'd100);
        do_tick();
        check("debounce_lives", lives, 3);
        check("debounce_invuln", invuln, 0);
        do_tick();
        check("debounce_hit_lives", lives, 2);

        // Reset mid-pipeline on the confirming tick: no hit survives.
        start_game();
        do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) begin tick = 1'b0; rst = 1'b0; end
        @(negedge clk) rst = 1'b1;
        o0 = over_cnt;
        repeat (4) @(negedge clk);
        check("midrst_lives", lives, 3);
        check("midrst_invuln", invuln, 0);

        // Game over: hits land on ticks 2, 36 and 70 under continuous contact.
        start_game();
        o0 = over_cnt;
        run_ticks(2);
        check("go_hit1_lives", lives, 2);
        run_ticks(31);
        check("go_t33_invuln", invuln, 1);
        do_tick();
        check("go_t34_invuln", invuln, 0);
        check("go_t34_lives", lives, 2);
        run_ticks(2);
        check("go_hit2_lives", lives, 1);
        run_ticks(33);
        check("go_t69_lives", lives, 1);
        do_tick();
        check("go_hit3_lives", lives, 0);
        check("go_over_pulse", over, 1);
        @(negedge clk);
        check("go_over_width", over, 0);
        run_ticks(3);
        check("go_hold_lives", lives, 0);
        check("go_over_cnt", over_cnt - o0, 1);
        @(negedge clk) running = 1'b0;
        @(negedge clk);
        check("go_idle_lives", lives, 3);

        // Success beats the final-hit confirmation at lives=1.
        start_game();
        o0 = over_cnt;
        s0 = succ_cnt;
        run_ticks(69);
        check("prio_pre_lives", lives, 1);
        set_queue(10'd100, 9'd100);
        do_tick();
        check("prio_success", success, 1);
        check("prio_lives", lives, 1);
        check("prio_over_cnt", over_cnt - o0, 0);
        run_ticks(2);
        check("prio_succ_cnt", succ_cnt - s0, 1);
        set_queue(10'd900, 9'd450);

        // Abort during INVULN after 12 immune ticks (icnt=20).
        start_game();
        run_ticks(14);
        check("abort_pre_invuln", invuln, 1);
        check("abort_pre_lives", lives, 2);
        @(negedge clk) running = 1'b0;
        @(negedge clk);
        check("abort_invuln", invuln, 0);
        check("abort_lives", lives, 3);
        running = 1'b1;
        @(negedge clk);
        do_tick();
        check("abort_first_tick_lives", lives, 3);
        do_tick();
        check("abort_second_tick_lives", lives, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_judge.md
# game_judge

Per-frame collision and win/lose judge for the game core. Samples Mario, barrel and queue centre positions on each game-update tick and tests axis-aligned overlap of their sprite boxes. Debounces contacts, tracks remaining lives and invulnerability, and emits one-cycle `over` / `success` pulses. Sits directly upstream of `state_fsm`, whose `over` and `success` inputs it drives.

## Interface
Parameters:
- `HIT_TICKS`, 2: consecutive contact ticks required to confirm a barrel hit (1..7).
- `LIVES`, 3: lives loaded on entry to play (1..3).
- `INVULN_TICKS`, 32: ticks of barrel immunity after a non-fatal hit (1..63).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `tick` in 1: one-`clk` strobe per game update, synchronous to `clk`.
- `running` in 1: high while game state is RUNNING.
- `mario_x` in 10, `mario_y` in 9: Mario centre; box 60×80.
- `barrel_x` in 10, `barrel_y` in 9: barrel centre; box 40×60.
- `queue_x` in 10, `queue_y` in 9: queue centre; box 60×100.
- `over` out 1: one-cycle pulse when the last life is lost.
- `success` out 1: one-cycle pulse when Mario reaches the queue.
- `lives` out 2: remaining lives.
- `invuln` out 1: high while immune.

## Operation
- Unsigned absolute differences: `dx = (a>=b) ? a-b : b-a`, 10-bit for x and 9-bit for y. No wrap is possible.
- Barrel contact: `dxb < 50` and `dyb < 70`, both strict.
- Queue contact: `dxq < 60` and `dyq < 90`, both strict.
- States:
  - **IDLE**: `lives=LIVES`, counters at 0. Goes to PLAY when `running=1`.
  - **PLAY**: on each tick with barrel contact, `hcnt` increments, saturating at `HIT_TICKS`. On a tick without contact, `hcnt` goes to 0. When `hcnt` reaches `HIT_TICKS`, a hit is confirmed:
    - `lives` decrements.
    - If the new `lives` is 0: pulse `over` and go to OVER.
    - Otherwise: load `icnt=INVULN_TICKS`, clear `hcnt`, go to INVULN.
  - **INVULN**: barrel contact is ignored and `hcnt` is held at 0. `icnt` decrements per tick. On the tick where `icnt` reaches 0, go to PLAY. Queue contact is still evaluated.
  - **OVER / WIN**: hold. Go to IDLE when `running=0`.
- Queue contact on a judged tick, in PLAY or INVULN: pulse `success` and go to WIN.
- Priority on the same tick: queue contact wins over a confirmed barrel hit. `lives` is not decremented and `over` is not pulsed.
- `running=0` in any state: go to IDLE on the next `clk`. `lives` reloads and counters clear. No pulses.
- `invuln=1` exactly while in INVULN.

## Timing
- Reset values:
  - `over=0`, `success=0`, `invuln=0`.
  - `lives=LIVES`.
  - State IDLE, all pipeline registers 0.
- 3-stage pipeline, advanced only by `tick`:
  - S1 (`tick` at cycle T): register positions and abs diffs.
  - S2 (T+1): register contact flags.
  - S3 (T+2): FSM update. `over`/`success` high during cycle T+3 only; `lives`/`invuln` update visible at T+3.
- `tick` spacing is ≥3 `clk`. Behaviour for closer ticks is not required.
- Inputs only need to be stable in the cycle where `tick=1`.
- `rst` asserted mid-pipeline clears everything immediately, with no pulse on release.
- `over` and `success` are never high in the same cycle. Each fires at most once per IDLE→PLAY entry.

## Test plan
- **Reset**: assert `rst=0` with `running=1` and overlapping boxes. Required: `over=0`, `success=0`, `lives=3`, `invuln=0`. After release, still no pulse before the first tick.
- **Barrel boundary**: Mario (100,100), barrel (149,169), `running=1`, 2 ticks. Required: `lives` 3→2 at T+3 of the 2nd tick, `invuln=1`. Repeat with barrel (150,100): no hit.
- **Debounce reset**: contact tick, no-contact tick, contact tick. Required: `lives` stays 3.
- **Game over**: continuous barrel contact through 3 hits, each hit separated by 32 invulnerable ticks. Required:
  - `lives` steps 3→2→1→0.
  - Exactly one `over` pulse, one cycle wide.
  - State holds until `running=0`, then `lives=3`.
- **Success with priority**: barrel and queue both overlapping Mario on the tick that would confirm the final hit (`lives=1`). Required: `success` pulse, no `over`, `lives` stays 1.
- **Abort**: drop `running` during INVULN with `icnt=20`. Required: next `clk` `invuln=0`, `lives=3`. Re-raising `running` with contact needs 2 fresh ticks before a hit.
